pcie_ltssm_monitor: RTL and testbench

Link-state monitor that consumes the 5-bit LTSSM state exported by the Gen1 x8 PCIe hard-IP wrapper (`hip_pipe_sim_ltssmstate`). It produces a debounced `link_up` qualifier and link-up/link-down event pulses for the application logic. It also keeps retrain and L0-residency counters, and records a timestamped trace of every LTSSM transition in a small FIFO. It sits directly downstream of the hard-IP wrapper, in the `clk_clk` domain.

---
 rtl/pcie_ltssm_pkg.sv | 36 +++
 rtl/pcie_ltssm_trace_fifo.sv | 77 +++++++
 rtl/pcie_ltssm_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_pcie_ltssm_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ltssm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : pcie_ltssm_pkg                                             |
// | Description : LTSSM encodings from the Gen1 x8 hard-IP wrapper, the      |
// |               link-monitor FSM state type and the trace entry layout.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pcie_ltssm_pkg;

    localparam logic [4:0] LTSSM_DETECT_QUIET = 5'h00;
    localparam logic [4:0] LTSSM_RCVLOCK      = 5'h0C;
    localparam logic [4:0] LTSSM_RCVCFG       = 5'h0D;
    localparam logic [4:0] LTSSM_RIDLE        = 5'h0E;
    localparam logic [4:0] LTSSM_L0           = 5'h0F;

    localparam int unsigned TS_W = 27;

    typedef enum logic [1:0] {
        MON_DOWN     = 2'd0,
        MON_QUAL     = 2'd1,
        MON_UP       = 2'd2,
        MON_RECOVERY = 2'd3
    } mon_state_e;

    typedef struct packed {
        logic [4:0]      ltssm;
        logic [TS_W-1:0] timestamp;
    } trace_entry_t;

    // Recovery sub-states that keep the link logically up.
    function automatic logic is_recovery(input logic [4:0] s);
        return (s >= LTSSM_RCVLOCK) && (s <= LTSSM_RIDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_ltssm_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pcie_ltssm_trace_fifo                                      |
// | Description : Single-clock FIFO holding LTSSM trace entries.             |
// |               clk, rst_n   : clock, asynchronous active-low reset        |
// |               flush        : synchronous empty; overrides push and pop   |
// |               push/push_data : write strobe and entry                    |
// |               pop          : read strobe (ignored when empty)            |
// |               pop_data     : head entry, zero while empty                |
// |               full, empty  : occupancy flags                             |
// |               A push into a full FIFO is accepted only when a pop        |
// |               happens on the same edge.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcie_ltssm_trace_fifo
    import pcie_ltssm_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  trace_entry_t push_data,
    input  logic         pop,
    output trace_entry_t pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    trace_entry_t mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop && !empty && !flush;
    assign wr_en = push && (!full || rd_en) && !flush;

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pcie_ltssm_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pcie_ltssm_monitor                                         |
// | Description : Debounced link-up qualifier, link event pulses, retrain    |
// |               and L0-residency counters, and a timestamped trace of      |
// |               LTSSM transitions.                                         |
// |   clk_clk, reset_reset_n : clock, asynchronous active-low reset          |
// |   ltssm_state            : LTSSM state from the hard IP                  |
// |   clear                  : clears counters, trace FIFO, overflow flag    |
// |   link_up                : debounced link-up level                       |
// |   link_up_pulse          : one cycle on QUAL -> UP                       |
// |   link_down_pulse        : one cycle on UP/RECOVERY -> DOWN              |
// |   retrain_count          : completed recoveries (saturating)             |
// |   l0_cycles              : cycles in UP (saturating)                     |
// |   trace_valid/ready/data : trace FIFO head, {ltssm, timestamp[26:0]}     |
// |   trace_overflow         : sticky, a transition was dropped              |
// | Build macro : PCIE_LTSSM_MON_TRACE_EN builds the trace FIFO, timestamp   |
// |               counter and overflow logic; otherwise trace outputs are 0. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcie_ltssm_monitor
    import pcie_ltssm_pkg::*;
#(
    parameter int unsigned DEBOUNCE    = 256,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [4:0]  ltssm_state,
    input  logic        clear,
    output logic        link_up,
    output logic        link_up_pulse,
    output logic        link_down_pulse,
    output logic [15:0] retrain_count,
    output logic [31:0] l0_cycles,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);

    localparam logic [15:0] DEBOUNCE_LAST = 16'(DEBOUNCE - 1);

    logic [4:0]  ltssm_q, ltssm_q2;
    mon_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        up_pulse_q, up_pulse_d;
    logic        down_pulse_q, down_pulse_d;
    logic        retrain_inc;
    logic [15:0] retrain_count_q, retrain_count_d;
    logic [31:0] l0_cycles_q, l0_cycles_d;

    // ---------------- FSM next-state / pulse decode ----------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        up_pulse_d   = 1'b0;
        down_pulse_d = 1'b0;
        retrain_inc  = 1'b0;
        case (state_q)
            MON_DOWN: begin
                if (ltssm_q == LTSSM_L0) begin
                    state_d = MON_QUAL;
                    cnt_d   = '0;
                end
            end
            MON_QUAL: begin
                if (ltssm_q != LTSSM_L0) begin
                    state_d = MON_DOWN;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    state_d    = MON_UP;
                    up_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MON_UP: begin
                if (ltssm_q == LTSSM_L0) begin
                    state_d = MON_UP;
                end else if (is_recovery(ltssm_q)) begin
                    state_d = MON_RECOVERY;
                end else begin
                    state_d      = MON_DOWN;
                    down_pulse_d = 1'b1;
                end
            end
            MON_RECOVERY: begin
                if (ltssm_q == LTSSM_L0) begin
                    state_d     = MON_UP;
                    retrain_inc = 1'b1;
                end else if (is_recovery(ltssm_q)) begin
                    state_d = MON_RECOVERY;
                end else begin
                    state_d      = MON_DOWN;
                    down_pulse_d = 1'b1;
                end
            end
            default: state_d = MON_DOWN;
        endcase
    end

    // ---------------- Saturating counters ----------------
    always_comb begin
        retrain_count_d = retrain_count_q;
        l0_cycles_d     = l0_cycles_q;
        if (clear) begin
            retrain_count_d = '0;
            l0_cycles_d     = '0;
        end else begin
            if (retrain_inc && (retrain_count_q != 16'hFFFF))
                retrain_count_d = retrain_count_q + 16'd1;
            if ((state_q == MON_UP) && (l0_cycles_q != 32'hFFFF_FFFF))
                l0_cycles_d = l0_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ltssm_q         <= LTSSM_DETECT_QUIET;
            ltssm_q2        <= LTSSM_DETECT_QUIET;
            state_q         <= MON_DOWN;
            cnt_q           <= '0;
            up_pulse_q      <= 1'b0;
            down_pulse_q    <= 1'b0;
            retrain_count_q <= '0;
            l0_cycles_q     <= '0;
        end else begin
            ltssm_q         <= ltssm_state;
            ltssm_q2        <= ltssm_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            up_pulse_q      <= up_pulse_d;
            down_pulse_q    <= down_pulse_d;
            retrain_count_q <= retrain_count_d;
            l0_cycles_q     <= l0_cycles_d;
        end
    end

    assign link_up         = (state_q == MON_UP) || (state_q == MON_RECOVERY);
    assign link_up_pulse   = up_pulse_q;
    assign link_down_pulse = down_pulse_q;
    assign retrain_count   = retrain_count_q;
    assign l0_cycles       = l0_cycles_q;

`ifdef PCIE_LTSSM_MON_TRACE_EN
    // ---------------- Transition trace ----------------
    logic [TS_W-1:0] ts_q, ts_d;
    logic            overflow_q, overflow_d;
    logic            trace_push;
    logic            trace_pop;
    logic            fifo_full;
    logic            fifo_empty;
    trace_entry_t    push_entry;
    trace_entry_t    head_entry;

    assign ts_d       = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
    assign trace_push = (ltssm_q != ltssm_q2);
    assign trace_pop  = !fifo_empty && trace_ready;
    assign push_entry = '{ltssm: ltssm_q, timestamp: ts_q};

    // Drop only when full and no pop frees a slot on the same edge.
    always_comb begin
        overflow_d = overflow_q;
        if (clear)
            overflow_d = 1'b0;
        else if (trace_push && fifo_full && !trace_pop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    pcie_ltssm_trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (clear),
        .push      (trace_push),
        .push_data (push_entry),
        .pop       (trace_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign trace_valid    = !fifo_empty;
    assign trace_data     = head_entry;
    assign trace_overflow = overflow_q;
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = ^{trace_ready, ltssm_q2, (TRACE_DEPTH > 32'd1)};

    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_ltssm_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pcie_ltssm_monitor                                      |
// | Description : Scoreboard bench for pcie_ltssm_monitor (DEBOUNCE=4,       |
// |               TRACE_DEPTH=4). Expected pulses, status snapshots and      |
// |               trace entries are queued with the stimulus; a monitor      |
// |               compares them as the DUT presents its outputs.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pcie_ltssm_monitor;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [4:0]  ltssm_state   = 5'h00;
    logic        clear         = 1'b0;
    logic        trace_ready   = 1'b1;
    logic        link_up;
    logic        link_up_pulse;
    logic        link_down_pulse;
    logic [15:0] retrain_count;
    logic [31:0] l0_cycles;
    logic        trace_valid;
    logic [31:0] trace_data;
    logic        trace_overflow;

    pcie_ltssm_monitor #(
        .DEBOUNCE    (4),
        .TRACE_DEPTH (4)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .ltssm_state     (ltssm_state),
        .clear           (clear),
        .link_up         (link_up),
        .link_up_pulse   (link_up_pulse),
        .link_down_pulse (link_down_pulse),
        .retrain_count   (retrain_count),
        .l0_cycles       (l0_cycles),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .trace_data      (trace_data),
        .trace_overflow  (trace_overflow)
    );

    always #5 clk_clk = ~clk_clk;

    // Edges since reset release; equals the DUT timestamp after each edge.
    int cyc = 0;
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) cyc <= 0;
        else                cyc <= cyc + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct { bit up; int cyc; } ev_t;
    typedef struct { logic [4:0] st; logic [26:0] ts; } tr_t;
    typedef struct { int cyc; bit lu; logic [15:0] rc; logic [31:0] l0; } st_t;

    ev_t ev_q[$];
    tr_t tr_q[$];
    st_t st_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_status(input int c, input bit lu, input logic [15:0] rc, input logic [31:0] l0);
        st_q.push_back('{c, lu, rc, l0});
    endtask

    task automatic exp_trace(input logic [4:0] s, input logic [26:0] ts);
        tr_q.push_back('{s, ts});
    endtask

    task automatic exp_event(input bit up, input int c);
        ev_q.push_back('{up, c});
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk_clk);
    endtask

    // ---------------- Monitor ----------------
    always begin : monitor
        ev_t e;
        tr_t t;
        st_t s;
        @(negedge clk_clk);
        #2;
        if (link_up_pulse || link_down_pulse) begin
            if (ev_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pulse_unexpected: up=%0b down=%0b at cycle %0d, expected no pulse",
                         link_up_pulse, link_down_pulse, cyc);
            end else begin
                e = ev_q.pop_front();
                chk("pulse_kind", {30'd0, link_up_pulse, link_down_pulse}, e.up ? 32'd2 : 32'd1);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
`ifdef PCIE_LTSSM_MON_TRACE_EN
        if (trace_valid && trace_ready) begin
            if (tr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL trace_unexpected: got %0h at cycle %0d, expected empty FIFO", trace_data, cyc);
            end else begin
                t = tr_q.pop_front();
                chk("trace_data", trace_data, {t.st, t.ts});
            end
        end
`endif
        while (reset_reset_n && (st_q.size() > 0) && (st_q[0].cyc <= cyc)) begin
            s = st_q.pop_front();
            chk("status_cycle", cyc, s.cyc);
            chk("link_up", {31'd0, link_up}, {31'd0, s.lu});
            chk("retrain_count", {16'd0, retrain_count}, {16'd0, s.rc});
            chk("l0_cycles", l0_cycles, s.l0);
`ifndef PCIE_LTSSM_MON_TRACE_EN
            chk("trace_valid_tied", {31'd0, trace_valid}, 32'd0);
`endif
        end
    end

    // ---------------- Watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    // ---------------- Stimulus ----------------
    initial begin
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        #1;
        chk("rst_link_up",      {31'd0, link_up},         32'd0);
        chk("rst_up_pulse",     {31'd0, link_up_pulse},   32'd0);
        chk("rst_down_pulse",   {31'd0, link_down_pulse}, 32'd0);
        chk("rst_retrain",      {16'd0, retrain_count},   32'd0);
        chk("rst_l0_cycles",    l0_cycles,                32'd0);
        chk("rst_trace_valid",  {31'd0, trace_valid},     32'd0);
        chk("rst_trace_data",   trace_data,               32'd0);
        chk("rst_overflow",     {31'd0, trace_overflow},  32'd0);

        // Short L0 burst: never qualifies.
        at_cycle(2);  ltssm_state = 5'h0F; exp_trace(5'h0F, 27'd3);
        at_cycle(4);  ltssm_state = 5'h0B; exp_trace(5'h0B, 27'd5);
        exp_status(7, 1'b0, 16'd0, 32'd0);

        // Link up: L0 registered at edge 11, UP after edge 16.
        at_cycle(10); ltssm_state = 5'h0F; exp_trace(5'h0F, 27'd11);
        exp_event(1'b1, 16);
        exp_status(15, 1'b0, 16'd0, 32'd0);
        exp_status(16, 1'b1, 16'd0, 32'd0);
        exp_status(20, 1'b1, 16'd0, 32'd4);
        exp_status(23, 1'b1, 16'd0, 32'd6);
        exp_status(26, 1'b1, 16'd1, 32'd6);
        exp_status(28, 1'b1, 16'd1, 32'd8);

        // Recovery RCVLOCK -> RCVCFG -> L0.
        at_cycle(20); ltssm_state = 5'h0C; exp_trace(5'h0C, 27'd21);
        at_cycle(22); ltssm_state = 5'h0D; exp_trace(5'h0D, 27'd23);
        at_cycle(24); ltssm_state = 5'h0F; exp_trace(5'h0F, 27'd25);

        // Saturation of retrain_count.
        at_cycle(30);
        force dut.retrain_count_q = 16'hFFFF;
        #1;
        release dut.retrain_count_q;
        exp_status(36, 1'b1, 16'hFFFF, 32'd14);
        at_cycle(31); ltssm_state = 5'h0C; exp_trace(5'h0C, 27'd32);
        at_cycle(33); ltssm_state = 5'h0F; exp_trace(5'h0F, 27'd34);

        // Link down from UP.
        at_cycle(40); ltssm_state = 5'h00; exp_trace(5'h00, 27'd41);
        exp_event(1'b0, 42);
        exp_status(42, 1'b0, 16'hFFFF, 32'd20);
        exp_status(45, 1'b0, 16'hFFFF, 32'd20);

        // Fill the 4-entry trace FIFO and overflow it with a fifth transition.
        at_cycle(50); trace_ready = 1'b0; ltssm_state = 5'h01; exp_trace(5'h01, 27'd51);
        at_cycle(52); ltssm_state = 5'h02; exp_trace(5'h02, 27'd53);
        at_cycle(54); ltssm_state = 5'h03; exp_trace(5'h03, 27'd55);
        at_cycle(56); ltssm_state = 5'h04; exp_trace(5'h04, 27'd57);
        at_cycle(58); ltssm_state = 5'h05;
        at_cycle(61);
`ifdef PCIE_LTSSM_MON_TRACE_EN
        chk("overflow_set",      {31'd0, trace_overflow}, 32'd1);
        chk("trace_valid_full",  {31'd0, trace_valid},    32'd1);
`else
        chk("overflow_tied",     {31'd0, trace_overflow}, 32'd0);
        chk("trace_valid_tied",  {31'd0, trace_valid},    32'd0);
`endif
        at_cycle(62); trace_ready = 1'b1;

        // Clear coinciding with a push: push discarded, overflow and counters zeroed.
        at_cycle(67); ltssm_state = 5'h06;
        chk("trace_drained", {31'd0, trace_valid}, 32'd0);
`ifdef PCIE_LTSSM_MON_TRACE_EN
        chk("overflow_sticky", {31'd0, trace_overflow}, 32'd1);
`endif
        at_cycle(68); clear = 1'b1;
        at_cycle(69); clear = 1'b0;
        exp_status(70, 1'b0, 16'd0, 32'd0);
        at_cycle(70);
        chk("clear_push_dropped", {31'd0, trace_valid},    32'd0);
        chk("clear_overflow",     {31'd0, trace_overflow}, 32'd0);

        // Link up again, then reset while UP.
        at_cycle(72); ltssm_state = 5'h0F; exp_trace(5'h0F, 27'd73);
        exp_event(1'b1, 78);
        exp_status(80, 1'b1, 16'd0, 32'd2);
        at_cycle(82);
        ltssm_state   = 5'h00;
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_link_up",    {31'd0, link_up},         32'd0);
        chk("mid_rst_up_pulse",   {31'd0, link_up_pulse},   32'd0);
        chk("mid_rst_down_pulse", {31'd0, link_down_pulse}, 32'd0);
        chk("mid_rst_l0_cycles",  l0_cycles,                32'd0);
        chk("mid_rst_retrain",    {16'd0, retrain_count},   32'd0);
        chk("mid_rst_trace_valid",{31'd0, trace_valid},     32'd0);
        chk("mid_rst_trace_data", trace_data,               32'd0);
        chk("mid_rst_overflow",   {31'd0, trace_overflow},  32'd0);
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        at_cycle(5);
        chk("post_rst_link_up",   {31'd0, link_up},         32'd0);
        chk("post_rst_l0_cycles", l0_cycles,                32'd0);

        // Every expected event, status and trace entry must have been consumed.
        chk("events_left", ev_q.size(), 32'd0);
        chk("status_left", st_q.size(), 32'd0);
`ifdef PCIE_LTSSM_MON_TRACE_EN
        chk("traces_left", tr_q.size(), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
